sfifo_if_bridge: RTL and testbench

SFIFO_IF_BRIDGE -- requirements
Module: sfifo_if_bridge

---
 rtl/sfifo_if_bridge.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_sfifo_if_bridge.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfifo_if_bridge.sv
// -----------------------------------------------------------------------------
// sfifo_if_bridge
//
// WISHBONE slave that bridges a small register map onto a sync-FIFO read port,
// a byte-wide mailbox, a set/reset DOUT command accumulator, a 32-bit DIN
// input and a bank of ADC channels. A base-period tick (bp_tick_i) drives a
// period counter, the underrun flag and the DOUT output update.
//
// Word map (wb_adr_i is the word offset):
//   0 BP_TICK (R)   1 CTRL (R/W)   2 SFIFO_DI (R)   3 DOUT (W)
//   4 DIN (R)       7 MBOX (W)     8+c ADC channel c (R)
//   Unmapped reads return 0; unmapped writes are acknowledged and ignored.
//
// Ports:
//   wb_clk_i, wb_rst_i    clock, synchronous active-high reset
//   wb_cyc_i .. wb_ack_o  WISHBONE slave (registered, single-cycle ack)
//   sfifo_rd_o            one-cycle pop strobe, coincident with SFIFO_DI ack
//   sfifo_empty_i/full_i  sync-FIFO status
//   sfifo_di              sync-FIFO head data
//   mbox_wr_o, mbox_do_o  mailbox byte write strobe and data
//   mbox_full_i/afull_i   mailbox status
//   bp_tick_i             base-period tick level
//   dout_set_o/dout_rst_o per-channel set/reset outputs, updated per period
//   din_i                 32-bit digital input
//   adc_i                 ADC_CH channels of ADC_W bits, channel c at [c*ADC_W +: ADC_W]
//   dbg_mbox_state        current mailbox FSM state (0 IDLE, 1 SEND)
//
// Configuration macro:
//   SFIFO_IF_DIN_LATCH_EN  defined: DIN reads din_i captured on each bp pulse.
//                          undefined: DIN reads din_i through a two-flop
//                          synchronizer.
// -----------------------------------------------------------------------------
module sfifo_if_bridge #(
    parameter int WB_AW    = 6,
    parameter int WB_DW    = 32,
    parameter int SFIFO_DW = 16,
    parameter int DOUT_W   = 16,
    parameter int ADC_CH   = 2,
    parameter int ADC_W    = 12
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [3:0]              wb_sel_i,
    input  logic [WB_AW-3:0]        wb_adr_i,
    input  logic [WB_DW-1:0]        wb_dat_i,
    output logic [WB_DW-1:0]        wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    sfifo_rd_o,
    input  logic                    sfifo_empty_i,
    input  logic                    sfifo_full_i,
    input  logic [SFIFO_DW-1:0]     sfifo_di,
    output logic                    mbox_wr_o,
    output logic [7:0]              mbox_do_o,
    input  logic                    mbox_full_i,
    input  logic                    mbox_afull_i,
    input  logic                    bp_tick_i,
    output logic [DOUT_W-1:0]       dout_set_o,
    output logic [DOUT_W-1:0]       dout_rst_o,
    input  logic [31:0]             din_i,
    input  logic [ADC_CH*ADC_W-1:0] adc_i,
    output logic [0:0]              dbg_mbox_state
);

    localparam int AW = WB_AW - 2;

    localparam logic [AW-1:0] A_BP    = AW'(0);
    localparam logic [AW-1:0] A_CTRL  = AW'(1);
    localparam logic [AW-1:0] A_SFIFO = AW'(2);
    localparam logic [AW-1:0] A_DOUT  = AW'(3);
    localparam logic [AW-1:0] A_DIN   = AW'(4);
    localparam logic [AW-1:0] A_MBOX  = AW'(7);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // -------------------------------------------------------------------------
    // Bus handshake. A request is cyc&stb; the slave answers with a registered
    // one-cycle ack in the cycle after the request is accepted. Acceptance is
    // withheld (the request simply waits, no ack) while a SFIFO_DI read finds
    // the FIFO empty, or while an MBOX write finds the mailbox busy or full.
    // Every side effect (pop, register write, mailbox latch) happens on the
    // same clock edge that raises ack, so each accepted access acts once.
    // -------------------------------------------------------------------------
    logic        bus_req;
    logic        hold;
    logic        ack_next;
    logic        rd_strobe;
    logic        wr_strobe;
    logic [0:0]  state;

    // The ~wb_ack_o term keeps the slave from re-accepting the same request
    // in the ack cycle, so ack never asserts on two consecutive cycles.
    assign bus_req   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign hold      = (~wb_we_i & (wb_adr_i == A_SFIFO) & sfifo_empty_i) |
                       ( wb_we_i & (wb_adr_i == A_MBOX) &
                        ((state != ST_IDLE) | mbox_full_i));
    assign ack_next  = bus_req & ~hold;
    assign rd_strobe = ack_next & ~wb_we_i;
    assign wr_strobe = ack_next &  wb_we_i;

    // -------------------------------------------------------------------------
    // Base-period tick: one input register, then a rising-edge detect on it.
    // -------------------------------------------------------------------------
    logic bp_q;
    logic bp_q2;
    logic bp_pulse;

    assign bp_pulse = bp_q & ~bp_q2;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            bp_q  <= 1'b0;
            bp_q2 <= 1'b0;
        end else begin
            bp_q  <= bp_tick_i;
            bp_q2 <= bp_q;
        end
    end

    logic [31:0] bp_cnt;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            bp_cnt <= 32'd0;
        end else if (bp_pulse) begin
            bp_cnt <= bp_cnt + 32'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Underrun: sticky, set by a period tick that finds the FIFO empty,
    // cleared by writing 1 to CTRL bit 4. A set in the same cycle wins.
    // -------------------------------------------------------------------------
    logic underrun;
    logic ctrl_clr;

    assign ctrl_clr = wr_strobe & (wb_adr_i == A_CTRL) & wb_sel_i[0] & wb_dat_i[4];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            underrun <= 1'b0;
        end else if (bp_pulse & sfifo_empty_i) begin
            underrun <= 1'b1;
        end else if (ctrl_clr) begin
            underrun <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // DIN source
    // -------------------------------------------------------------------------
    logic [31:0] din_q;

`ifdef SFIFO_IF_DIN_LATCH_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            din_q <= 32'd0;
        end else if (bp_pulse) begin
            din_q <= din_i;
        end
    end
`else
    logic [31:0] din_meta;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            din_meta <= 32'd0;
            din_q    <= 32'd0;
        end else begin
            din_meta <= din_i;
            din_q    <= din_meta;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // DOUT command accumulators. A command carries valid/value/channel in the
    // top byte; the latest command for a channel within a period wins. At the
    // period tick the outputs take the accumulators, which restart empty; a
    // command accepted on that same edge lands in the fresh accumulators.
    // -------------------------------------------------------------------------
    logic              dout_cmd;
    logic [DOUT_W-1:0] ch_onehot;
    logic [DOUT_W-1:0] set_acc;
    logic [DOUT_W-1:0] rst_acc;
    logic [DOUT_W-1:0] set_acc_n;
    logic [DOUT_W-1:0] rst_acc_n;

    // One-hot is all-zero for a channel number at or beyond DOUT_W, which
    // makes such commands no-ops without a separate range check.
    always_comb begin
        ch_onehot = '0;
        for (int i = 0; i < DOUT_W; i++) begin
            if (wb_dat_i[29:24] == 6'(i)) begin
                ch_onehot[i] = 1'b1;
            end
        end
    end

    assign dout_cmd = wr_strobe & (wb_adr_i == A_DOUT) & wb_sel_i[3] & wb_dat_i[31];

    always_comb begin
        set_acc_n = bp_pulse ? '0 : set_acc;
        rst_acc_n = bp_pulse ? '0 : rst_acc;
        if (dout_cmd) begin
            if (wb_dat_i[30]) begin
                set_acc_n = set_acc_n |  ch_onehot;
                rst_acc_n = rst_acc_n & ~ch_onehot;
            end else begin
                set_acc_n = set_acc_n & ~ch_onehot;
                rst_acc_n = rst_acc_n |  ch_onehot;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            set_acc    <= '0;
            rst_acc    <= '0;
            dout_set_o <= '0;
            dout_rst_o <= '0;
        end else begin
            set_acc <= set_acc_n;
            rst_acc <= rst_acc_n;
            if (bp_pulse) begin
                dout_set_o <= set_acc;
                dout_rst_o <= rst_acc;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Mailbox FSM. An accepted MBOX write latches the word and its byte
    // enables, then SEND streams the enabled lanes lowest first. The lane on
    // mbox_do_o is always the lowest still pending, so disabled lanes cost no
    // cycles. A byte retires only in a cycle where mbox_wr_o is high.
    // -------------------------------------------------------------------------
    logic [31:0] mbox_data;
    logic [3:0]  pend;
    logic [3:0]  pend_after;
    logic [1:0]  lane;
    logic        mbox_accept;

    assign mbox_accept = wr_strobe & (wb_adr_i == A_MBOX);

    always_comb begin
        lane = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pend[i]) begin
                lane = 2'(i);
            end
        end
    end

    always_comb begin
        case (lane)
            2'd0:    mbox_do_o = mbox_data[7:0];
            2'd1:    mbox_do_o = mbox_data[15:8];
            2'd2:    mbox_do_o = mbox_data[23:16];
            default: mbox_do_o = mbox_data[31:24];
        endcase
    end

    assign pend_after     = pend & ~(4'b0001 << lane);
    assign mbox_wr_o      = (state == ST_SEND) & ~mbox_full_i;
    assign dbg_mbox_state = state;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            pend      <= 4'd0;
            mbox_data <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A write with no lanes enabled is acked and does nothing.
                    if (mbox_accept && (wb_sel_i != 4'd0)) begin
                        mbox_data <= wb_dat_i[31:0];
                        pend      <= wb_sel_i;
                        state     <= ST_SEND;
                    end
                end
                default: begin
                    if (mbox_wr_o) begin
                        pend <= pend_after;
                        if (pend_after == 4'd0) begin
                            state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Read data mux. Narrow sources are left-justified in the 32-bit word.
    // -------------------------------------------------------------------------
    logic [31:0] rd_word;

    always_comb begin
        rd_word = 32'd0;
        case (wb_adr_i)
            A_BP:    rd_word = bp_cnt;
            A_CTRL:  rd_word = {27'd0, underrun, mbox_afull_i, mbox_full_i,
                                sfifo_full_i, sfifo_empty_i};
            A_SFIFO: rd_word = 32'(sfifo_di) << (32 - SFIFO_DW);
            A_DIN:   rd_word = din_q;
            default: begin
                for (int c = 0; c < ADC_CH; c++) begin
                    if (wb_adr_i == AW'(8 + c)) begin
                        rd_word = 32'(adc_i[c*ADC_W +: ADC_W]) << (32 - ADC_W);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o   <= 1'b0;
            sfifo_rd_o <= 1'b0;
            wb_dat_o   <= '0;
        end else begin
            wb_ack_o   <= ack_next;
            sfifo_rd_o <= rd_strobe & (wb_adr_i == A_SFIFO);
            wb_dat_o   <= rd_strobe ? WB_DW'(rd_word) : '0;
        end
    end

endmodule

// File: tb/tb_sfifo_if_bridge.sv
// -----------------------------------------------------------------------------
// tb_sfifo_if_bridge
//
// Directed bench for sfifo_if_bridge with default parameters. Inputs are
// driven 1 ns after the rising edge; outputs are sampled on the falling edge.
// Read results go through an expected queue; mailbox bytes go through a
// second expected queue drained by a monitor.
// -----------------------------------------------------------------------------
module tb_sfifo_if_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [3:0]  adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic        sfifo_rd;
    logic        sfifo_empty;
    logic        sfifo_full;
    logic [15:0] sfifo_di;
    logic        mbox_wr;
    logic [7:0]  mbox_do;
    logic        mbox_full;
    logic        mbox_afull;
    logic        bp_tick;
    logic [15:0] dout_set;
    logic [15:0] dout_rst;
    logic [31:0] din;
    logic [23:0] adc;
    logic [0:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    int mb_pulses = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  mb_q[$];

    sfifo_if_bridge dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wb_cyc_i      (cyc),
        .wb_stb_i      (stb),
        .wb_we_i       (we),
        .wb_sel_i      (sel),
        .wb_adr_i      (adr),
        .wb_dat_i      (dat_w),
        .wb_dat_o      (dat_r),
        .wb_ack_o      (ack),
        .sfifo_rd_o    (sfifo_rd),
        .sfifo_empty_i (sfifo_empty),
        .sfifo_full_i  (sfifo_full),
        .sfifo_di      (sfifo_di),
        .mbox_wr_o     (mbox_wr),
        .mbox_do_o     (mbox_do),
        .mbox_full_i   (mbox_full),
        .mbox_afull_i  (mbox_afull),
        .bp_tick_i     (bp_tick),
        .dout_set_o    (dout_set),
        .dout_rst_o    (dout_rst),
        .din_i         (din),
        .adc_i         (adc),
        .dbg_mbox_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_read(input logic [3:0] a, output logic [31:0] d, output logic ok);
        drive_step();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        ok = 1'b0;
        d  = 32'd0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                d  = dat_r;
                ok = 1'b1;
                break;
            end
        end
        drive_step();
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic wb_write(input string tag, input logic [3:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        logic ok;
        drive_step();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; sel = s; dat_w = d;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_ack"}, 32'(ok), 32'd1);
        drive_step();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] e);
        logic [31:0] d;
        logic        ok;
        logic [31:0] e_pop;
        exp_q.push_back(e);
        wb_read(a, d, ok);
        check({tag, "_ack"}, 32'(ok), 32'd1);
        e_pop = exp_q.pop_front();
        if (ok) check(tag, d, e_pop);
    endtask

    task automatic bp_pulse();
        drive_step();
        bp_tick = 1'b1;
        repeat (4) drive_step();
        bp_tick = 1'b0;
        repeat (4) drive_step();
    endtask

    // ---------------- mailbox monitor ----------------
    always @(negedge clk) begin
        if (mbox_wr === 1'b1) begin
            logic [7:0] eb;
            mb_pulses++;
            check("mbox_wr_while_full", 32'(mbox_full), 32'd0);
            check("mbox_byte_expected", 32'(mb_q.size() != 0), 32'd1);
            if (mb_q.size() != 0) begin
                eb = mb_q.pop_front();
                check("mbox_byte", 32'(mbox_do), 32'(eb));
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int   pulses_before;
        logic got;
        logic rd_seen;

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 4'h0;
        dat_w = 32'd0; sfifo_empty = 1'b1; sfifo_full = 1'b0; sfifo_di = 16'h0;
        mbox_full = 1'b0; mbox_afull = 1'b0; bp_tick = 1'b0;
        din = 32'd0; adc = {12'hABC, 12'h123};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_sfifo_rd", 32'(sfifo_rd), 32'd0);
        check("rst_mbox_wr", 32'(mbox_wr), 32'd0);
        check("rst_dat_o", dat_r, 32'd0);
        check("rst_dout_set", 32'(dout_set), 32'd0);
        check("rst_dout_rst", 32'(dout_rst), 32'd0);
        check("rst_fsm_idle", 32'(dbg_state), 32'd0);
        drive_step();
        rst = 1'b0;

        rd_chk("bp_tick_reset", 4'd0, 32'd0);
        rd_chk("ctrl_reset", 4'd1, 32'h0000_0001);

        // period counter and underrun (FIFO empty at both ticks)
        bp_pulse();
        bp_pulse();
        rd_chk("bp_tick_two", 4'd0, 32'd2);
        rd_chk("ctrl_underrun_set", 4'd1, 32'h0000_0011);
        wb_write("ctrl_clear", 4'd1, 32'h0000_0010, 4'hF);
        rd_chk("ctrl_underrun_clr", 4'd1, 32'h0000_0001);

        // SFIFO_DI read stalls while empty, then pops once with the ack
        drive_step();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'd2; sel = 4'hF;
        exp_q.push_back(32'hBEEF_0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("sfifo_no_ack_empty", 32'({ack, sfifo_rd}), 32'd0);
        end
        drive_step();
        sfifo_empty = 1'b0; sfifo_di = 16'hBEEF;
        got = 1'b0; rd_seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                logic [31:0] e;
                got = 1'b1;
                rd_seen = sfifo_rd;
                e = exp_q.pop_front();
                check("sfifo_data", dat_r, e);
                break;
            end
        end
        check("sfifo_ack", 32'(got), 32'd1);
        check("sfifo_rd_with_ack", 32'(rd_seen), 32'd1);
        drive_step();
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        check("sfifo_rd_one_cycle", 32'({ack, sfifo_rd}), 32'd0);

        // DIN after a period tick (valid in both DIN source builds)
        din = 32'hA5A5_1234;
        bp_pulse();
        rd_chk("din", 4'd4, 32'hA5A5_1234);

        // ADC channels and unmapped addresses
        rd_chk("adc_ch0", 4'd8, 32'h1230_0000);
        rd_chk("adc_ch1", 4'd9, 32'hABC0_0000);
        rd_chk("adc_unmapped", 4'd10, 32'd0);
        rd_chk("dout_read_zero", 4'd3, 32'd0);
        wb_write("unmapped_write", 4'd5, 32'hFFFF_FFFF, 4'hF);

        // MBOX write with no lanes: acked, no bytes
        pulses_before = mb_pulses;
        wb_write("mbox_sel0", 4'd7, 32'h1234_5678, 4'h0);
        repeat (3) @(negedge clk);
        check("mbox_sel0_no_pulse", 32'(mb_pulses - pulses_before), 32'd0);
        check("mbox_sel0_idle", 32'(dbg_state), 32'd0);

        // MBOX burst with lane 2 disabled and backpressure mid-burst
        pulses_before = mb_pulses;
        mb_q.push_back(8'h11);
        mb_q.push_back(8'h22);
        mb_q.push_back(8'h44);
        wb_write("mbox_burst", 4'd7, 32'h4433_2211, 4'b1011);
        mbox_full = 1'b1;
        @(negedge clk);
        check("mbox_stall_no_wr", 32'(mbox_wr), 32'd0);
        drive_step();
        drive_step();
        mbox_full = 1'b0;
        repeat (8) @(negedge clk);
        check("mbox_burst_pulses", 32'(mb_pulses - pulses_before), 32'd3);
        check("mbox_burst_drained", 32'(mb_q.size()), 32'd0);
        check("mbox_burst_idle", 32'(dbg_state), 32'd0);

        // DOUT: last command per channel wins; invalid / out of range ignored
        wb_write("dout_85", 4'd3, 32'h8500_0000, 4'b1000);
        wb_write("dout_c5", 4'd3, 32'hC500_0000, 4'b1000);
        wb_write("dout_inv", 4'd3, 32'h4600_0000, 4'b1000);
        wb_write("dout_ch20", 4'd3, 32'hD400_0000, 4'b1000);
        wb_write("dout_nolane", 4'd3, 32'hC100_0000, 4'b0111);
        wb_write("dout_8a", 4'd3, 32'h8A00_0000, 4'b1000);
        bp_pulse();
        @(negedge clk);
        check("dout_set_p1", 32'(dout_set), 32'h0000_0020);
        check("dout_rst_p1", 32'(dout_rst), 32'h0000_0400);
        bp_pulse();
        @(negedge clk);
        check("dout_set_p2", 32'(dout_set), 32'd0);
        check("dout_rst_p2", 32'(dout_rst), 32'd0);

        // command accepted on the tick edge goes to the next period
        wb_write("dout_87", 4'd3, 32'h8700_0000, 4'b1000);
        drive_step();
        bp_tick = 1'b1;
        wb_write("dout_c3_tick", 4'd3, 32'hC300_0000, 4'b1000);
        bp_tick = 1'b0;
        @(negedge clk);
        check("dout_set_tick", 32'(dout_set), 32'd0);
        check("dout_rst_tick", 32'(dout_rst), 32'h0000_0080);
        repeat (4) drive_step();
        bp_pulse();
        @(negedge clk);
        check("dout_set_next", 32'(dout_set), 32'h0000_0008);
        check("dout_rst_next", 32'(dout_rst), 32'd0);

        // counter wrap and underrun set/clear, set winning over clear
        sfifo_empty = 1'b1; sfifo_full = 1'b1; mbox_afull = 1'b1;
        force dut.bp_cnt = 32'hFFFF_FFFF;
        rd_chk("bp_tick_max", 4'd0, 32'hFFFF_FFFF);
        release dut.bp_cnt;
        bp_pulse();
        rd_chk("bp_tick_wrap", 4'd0, 32'd0);
        rd_chk("ctrl_full_set", 4'd1, 32'h0000_001B);
        wb_write("ctrl_clear2", 4'd1, 32'h0000_0010, 4'hF);
        rd_chk("ctrl_cleared", 4'd1, 32'h0000_000B);
        drive_step();
        bp_tick = 1'b1;
        wb_write("ctrl_clear_tick", 4'd1, 32'h0000_0010, 4'hF);
        bp_tick = 1'b0;
        repeat (4) drive_step();
        rd_chk("ctrl_set_wins", 4'd1, 32'h0000_001B);
        rd_chk("bp_tick_after_wrap", 4'd0, 32'd1);

        // load outputs, then reset in the middle of a mailbox burst
        sfifo_empty = 1'b0; sfifo_full = 1'b0; mbox_afull = 1'b0;
        wb_write("dout_c1", 4'd3, 32'hC100_0000, 4'b1000);
        bp_pulse();
        @(negedge clk);
        check("dout_set_pre_rst", 32'(dout_set), 32'h0000_0002);
        mb_q.push_back(8'hAA);
        mb_q.push_back(8'hBB);
        wb_write("mbox_rst_burst", 4'd7, 32'hDDCC_BBAA, 4'hF);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_send_wr", 32'(mbox_wr), 32'd0);
        check("rst_mid_send_idle", 32'(dbg_state), 32'd0);
        check("rst_mid_send_drained", 32'(mb_q.size()), 32'd0);
        check("rst2_dout_set", 32'(dout_set), 32'd0);
        drive_step();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst2_no_more_bytes", 32'(mbox_wr), 32'd0);
        rd_chk("bp_tick_rst2", 4'd0, 32'd0);
        rd_chk("ctrl_rst2", 4'd1, 32'd0);

        check("read_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
